// File: rtl/turn_sequencer.sv
// turn_sequencer: roll/move/settle/check turn controller for the two-player snakes-and-ladders datapath.
// Dice come from an 8-bit LFSR with rejection of 0/7 and a bounded fallback to 1.
module turn_sequencer #(
  parameter logic [7:0] LFSR_SEED         = 8'h01,
  parameter int         SETTLE_CYCLES     = 2,
  parameter bit         EXTRA_TURN_ON_SIX = 1'b1,
  parameter int         MAX_REJECT        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_btn,
  input  logic       win1,
  input  logic       win2,
  input  logic       force_en,
  input  logic [2:0] force_value,
  output logic [2:0] dice_value,
  output logic       player_sel,
  output logic       move_en,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] turn_count
);
  typedef enum logic [2:0] {IDLE, ROLL, MOVE, SETTLE, CHECK, OVER} state_t;
  localparam logic [7:0] REJ_LIM = 8'(MAX_REJECT);
  state_t     state_q;
  logic [7:0] lfsr_q, rej_q, turn_q;
  logic [3:0] settle_q;
  logic [2:0] dice_q;
  logic [1:0] winner_q;
  logic       btn_q, player_q, move_q, busy_q, over_q;
  logic       rise, draw_ok, give_up, win;
  logic [2:0] forced;
  assign rise    = roll_btn & ~btn_q;
  assign forced  = (force_value == 3'd0 || force_value == 3'd7) ? 3'd1 : force_value;
  assign draw_ok = lfsr_q[2:0] != 3'd0 && lfsr_q[2:0] != 3'd7;
  assign give_up = rej_q + 8'd1 >= REJ_LIM;
  // Only the active player's flag can end the game.
  assign win     = player_q ? win1 : win2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      rej_q    <= 8'd0;
      turn_q   <= 8'd0;
      settle_q <= 4'd0;
      dice_q   <= 3'd1;
      winner_q <= 2'b00;
      btn_q    <= 1'b0;
      player_q <= 1'b1;
      move_q   <= 1'b0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      btn_q  <= roll_btn;
      move_q <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          state_q <= ROLL;
          rej_q   <= 8'd0;
          busy_q  <= 1'b1;
        end
        ROLL: if (force_en || draw_ok || give_up) begin
          dice_q  <= force_en ? forced : draw_ok ? lfsr_q[2:0] : 3'd1;
          state_q <= MOVE;
          move_q  <= 1'b1;
        end else rej_q <= rej_q + 8'd1;
        MOVE: begin
          settle_q <= 4'(SETTLE_CYCLES);
          state_q  <= SETTLE;
        end
        SETTLE: begin
          settle_q <= settle_q - 4'd1;
          if (settle_q == 4'd1) state_q <= CHECK;
        end
        CHECK: begin
          turn_q <= turn_q + {7'd0, turn_q != 8'hff};
          busy_q <= 1'b0;
          if (win) begin
            state_q  <= OVER;
            over_q   <= 1'b1;
            winner_q <= player_q ? 2'b01 : 2'b10;
          end else begin
            state_q <= IDLE;
            if (!(EXTRA_TURN_ON_SIX && dice_q == 3'd6)) player_q <= ~player_q;
          end
        end
        default: ;
      endcase
    end
  end
  assign dice_value = dice_q;
  assign player_sel = player_q;
  assign move_en    = move_q;
  assign busy       = busy_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign turn_count = turn_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: timeline-based reference model of a turn, checked every cycle, plus directed literal checks.
module tb_turn_sequencer;
  localparam int S     = 2;
  localparam int MAXR  = 8;
  localparam bit EXTRA = 1'b1;
  logic       clk = 1'b0;
  logic       reset, roll_btn, win1, win2, force_en;
  logic [2:0] force_value, dice_value;
  logic       player_sel, move_en, busy, game_over;
  logic [1:0] winner;
  logic [7:0] turn_count;
  int n_err = 0, n_checks = 0, moves = 0;
  int m_lfsr, m_dice, m_psel, m_over, m_winner, m_tc, m_prev;
  int m_in, m_roll, m_rej, m_move_at, m_check_at, c;

  always #5 clk = ~clk;

  turn_sequencer #(
    .LFSR_SEED(8'h01), .SETTLE_CYCLES(S), .EXTRA_TURN_ON_SIX(EXTRA), .MAX_REJECT(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .roll_btn(roll_btn), .win1(win1), .win2(win2),
    .force_en(force_en), .force_value(force_value), .dice_value(dice_value),
    .player_sel(player_sel), .move_en(move_en), .busy(busy), .game_over(game_over),
    .winner(winner), .turn_count(turn_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic m_reset();
    m_lfsr = 1; m_dice = 1; m_psel = 1; m_over = 0; m_winner = 0; m_tc = 0; m_prev = 0;
    m_in = 0; m_roll = 0; m_rej = 0; m_move_at = -1; m_check_at = -1; c = 0;
  endtask

  // A turn is a timeline: roll cycles until a value is accepted, then the move
  // one cycle later and the win check S+1 cycles after the move.
  task automatic m_step();
    int  acc, fv, lv;
    bit  rise;
    rise   = roll_btn && m_prev == 0;
    m_prev = int'(roll_btn);
    fv     = (force_value == 3'd0 || force_value == 3'd7) ? 1 : int'(force_value);
    lv     = m_lfsr % 8;
    if (m_in == 0) begin
      if (rise && m_over == 0) begin m_in = 1; m_roll = 1; m_rej = 0; end
    end else if (m_roll != 0) begin
      acc = force_en ? fv : (lv >= 1 && lv <= 6) ? lv : (m_rej + 1 >= MAXR) ? 1 : 0;
      if (acc == 0) m_rej++;
      else begin
        m_dice = acc; m_roll = 0; m_move_at = c + 1; m_check_at = c + 2 + S;
      end
    end else if (c == m_check_at) begin
      m_in = 0;
      m_tc = m_tc < 255 ? m_tc + 1 : 255;
      if (m_psel != 0 ? win1 : win2) begin
        m_over = 1; m_winner = m_psel != 0 ? 1 : 2;
      end else if (!(EXTRA && m_dice == 6)) m_psel = 1 - m_psel;
    end
    m_lfsr = ((m_lfsr << 1) & 255) | ($countones(m_lfsr & 8'hB8) & 1);
    c++;
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (reset) m_reset();
      chk("dice_value", int'(dice_value), m_dice);
      chk("player_sel", int'(player_sel), m_psel);
      chk("move_en", int'(move_en), int'(c == m_move_at));
      chk("busy", int'(busy), m_in);
      chk("game_over", int'(game_over), m_over);
      chk("winner", int'(winner), m_winner);
      chk("turn_count", int'(turn_count), m_tc);
      if (move_en) begin
        moves++;
        chk("dice_range", int'(dice_value >= 3'd1 && dice_value <= 3'd6), 1);
      end
      if (!reset) m_step();
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin tick(1); n++; end
    chk("turn_done", int'(busy), 0);
  endtask

  task automatic roll(input int fv);
    force_en = 1'b1; force_value = 3'(fv);
    roll_btn = 1'b1; tick(1); roll_btn = 1'b0;
    wait_idle();
  endtask

  initial begin
    int m0;
    reset = 1'b1; roll_btn = 1'b0; win1 = 1'b0; win2 = 1'b0; force_en = 1'b0; force_value = 3'd0;
    tick(3); reset = 1'b0; tick(10);
    chk("rst_dice", int'(dice_value), 1);
    chk("rst_psel", int'(player_sel), 1);
    chk("rst_move", int'(move_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_turns", int'(turn_count), 0);
    m0 = moves; roll(4);
    chk("f4_dice", int'(dice_value), 4);
    chk("f4_psel", int'(player_sel), 0);
    chk("f4_turns", int'(turn_count), 1);
    chk("f4_moves", moves - m0, 1);
    roll(6);
    chk("f6_dice", int'(dice_value), 6);
    chk("f6_psel_kept", int'(player_sel), 0);
    roll(7);
    chk("f7_dice", int'(dice_value), 1);
    chk("f7_psel", int'(player_sel), 1);
    m0 = moves; force_en = 1'b1; force_value = 3'd2;
    roll_btn = 1'b1; tick(3); roll_btn = 1'b0; tick(1); roll_btn = 1'b1;
    wait_idle(); tick(3); roll_btn = 1'b0; tick(1);
    chk("held_moves", moves - m0, 1);
    chk("held_psel", int'(player_sel), 0);
    win1 = 1'b1; roll(5); win1 = 1'b0;
    chk("inactive_win_over", int'(game_over), 0);
    chk("inactive_win_psel", int'(player_sel), 1);
    roll(1);
    chk("f1_psel", int'(player_sel), 0);
    force_en = 1'b1; force_value = 3'd3;
    roll_btn = 1'b1; tick(1); roll_btn = 1'b0; tick(2); win2 = 1'b1;
    wait_idle(); win2 = 1'b0;
    chk("win_over", int'(game_over), 1);
    chk("win_winner", int'(winner), 2);
    chk("win_turns", int'(turn_count), 7);
    m0 = moves;
    repeat (3) begin roll_btn = 1'b1; tick(2); roll_btn = 1'b0; tick(6); end
    chk("over_moves", moves - m0, 0);
    chk("over_turns", int'(turn_count), 7);
    chk("over_busy", int'(busy), 0);
    reset = 1'b1; roll_btn = 1'b1; force_en = 1'b0; tick(2);
    reset = 1'b0; tick(1); roll_btn = 1'b0;
    wait_idle();
    chk("lfsr_first_dice", int'(dice_value), 2);
    chk("lfsr_first_psel", int'(player_sel), 0);
    for (int i = 0; i < 30; i++) begin
      force_en    = $urandom_range(3) == 0;
      force_value = 3'($urandom_range(7));
      win1        = i >= 24 && $urandom_range(3) == 0;
      win2        = i >= 24 && $urandom_range(3) == 0;
      roll_btn = 1'b1; tick($urandom_range(3) + 1); roll_btn = 1'b0;
      wait_idle(); tick($urandom_range(2));
    end
    win1 = 1'b0; win2 = 1'b0;
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    force_en = 1'b1; force_value = 3'd5;
    roll_btn = 1'b1; tick(1); roll_btn = 1'b0; tick(2);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1; tick(1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_dice", int'(dice_value), 1);
    chk("mid_rst_psel", int'(player_sel), 1);
    chk("mid_rst_over", int'(game_over), 0);
    m0 = moves; reset = 1'b0; tick(10);
    chk("mid_rst_moves", moves - m0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Upstream control stage for the two-player snakes-and-ladders datapath.
- Converts a roll button into a validated dice value (1..6) from an internal LFSR, selects the active player, and issues a one-cycle move strobe to the position/snake-ladder stage.
- Waits for that stage to settle, samples its win flags, then hands the turn over or locks the game.
- Replaces the behavioural $random dice with synthesizable logic.

Parameters:
- LFSR_SEED, 8'h01, initial LFSR state; must be nonzero.
- SETTLE_CYCLES, 2, cycles waited after move_en before sampling win flags; legal range 1..15.
- EXTRA_TURN_ON_SIX, 1, when 1 a roll of 6 without a win keeps the same player.
- MAX_REJECT, 8, rejected LFSR draws tolerated before the fallback value is used.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- roll_btn  input  1  roll request, synchronous level; only a rising edge is acted on
- win1  input  1  player 1 win flag from the downstream stage
- win2  input  1  player 2 win flag from the downstream stage
- force_en  input  1  debug: use force_value instead of the LFSR draw
- force_value  input  3  debug dice value; 0 or 7 are treated as 1
- dice_value  output  3  accepted dice value, held until the next accepted roll
- player_sel  output  1  1 = player 1 active, 0 = player 2 (matches downstream player_switch)
- move_en  output  1  one-cycle strobe telling the downstream stage to commit a move
- busy  output  1  high in every state except IDLE and OVER
- game_over  output  1  sticky; high in OVER
- winner  output  2  2'b01 = player 1, 2'b10 = player 2, 2'b00 = none
- turn_count  output  8  completed turns, saturating at 255

Behaviour:
- Reset: async; forces state IDLE, lfsr=LFSR_SEED, dice_value=3'd1, player_sel=1, move_en=0, busy=0, game_over=0, winner=0, turn_count=0, roll_btn edge register=0.
- LFSR:
  - 8-bit Fibonacci, shifts left every clock out of reset.
  - New bit0 = l[7]^l[5]^l[4]^l[3].
  - Sequence from 8'h01: 01,02,04,08,11,23,47.
- Edge detect: rise = roll_btn & ~roll_btn_q. roll_btn_q updates every cycle. A rise in any state other than IDLE is discarded and is not queued.
- States:
  - IDLE: on rise, go to ROLL and clear the reject counter.
  - ROLL:
    - If force_en, accept force_value (0/7 become 1) in the same cycle.
    - Otherwise accept lfsr[2:0] if it is in 1..6; else increment the reject counter and stay.
    - If the reject counter reaches MAX_REJECT, accept 3'd1.
    - On accept: register dice_value, go to MOVE.
  - MOVE: move_en=1 for exactly this one cycle; load the settle counter with SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to CHECK.
  - CHECK: sample the win flag of the active player only (win1 if player_sel=1, else win2). turn_count increments (saturating).
    - Win: set winner, game_over=1, go to OVER.
    - No win, with dice_value==6 and EXTRA_TURN_ON_SIX: keep player_sel.
    - No win, otherwise: toggle player_sel.
    - No-win cases go to IDLE.
  - OVER: terminal; all roll requests are ignored and move_en stays 0 until reset.
- Latency: rise sampled in IDLE → move_en asserted 2 cycles later when the draw is accepted first time (IDLE→ROLL→MOVE). CHECK occurs SETTLE_CYCLES+1 cycles after MOVE.
- The inactive player's win flag is ignored. If both flags are high in CHECK, only the active player's flag counts.
- dice_value and player_sel are stable from the MOVE cycle through CHECK.
- Reset mid-turn (any state) aborts the turn immediately; no move_en is emitted afterwards.

Test Plan:
- Reset, then hold idle 10 cycles → dice_value=1, player_sel=1, move_en=0, busy=0, winner=0, turn_count=0.
- force_en=1, force_value=4, pulse roll_btn → move_en high exactly one cycle, 2 cycles after the sampled edge. dice_value=4. After CHECK (win1=0): player_sel=0, turn_count=1.
- force_value=6, EXTRA_TURN_ON_SIX=1, no win → player_sel unchanged. Then force_value=7 → dice_value=1 and player_sel toggles.
- Player 2 active, force_value=3, win2 driven high during SETTLE → game_over=1, winner=2'b10. Subsequent roll_btn pulses produce no move_en; turn_count frozen.
- Hold roll_btn high across an entire turn, and pulse it again during SETTLE → exactly one move_en. Also assert win1 while player 2 is active → no game_over.
- force_en=0, LFSR_SEED=8'h01, rise sampled at cycle 0 → every accepted dice_value is in 1..6 and matches the bench LFSR model. Assert reset during SETTLE → all outputs return to reset values and no move_en follows.
